memory_cycle: RTL and testbench

MEM stage of the five-stage RV32I pipeline. It consumes the EX/MEM pipeline register contents, resolves branches and jumps, and drives flush and the redirect PC. It performs load/store accesses over a request/acknowledge data-memory port, stalling the pipeline until acknowledge. It registers results into the MEM/WB pipeline register and returns ALU data to EX for forwarding.

---
 rtl/mem_pkg.sv | 35 +++
 rtl/lsu_align.sv | 53 +++++
 rtl/memory_cycle.sv | 216 +++++++++++++++++++++
 tb/tb_memory_cycle.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared encodings for the MEM stage: access sizes, write-back selects,
// control-flow opcodes and the data-memory handshake FSM states.
package mem_pkg;

    localparam logic [2:0] SLT_B  = 3'b000;
    localparam logic [2:0] SLT_H  = 3'b001;
    localparam logic [2:0] SLT_W  = 3'b010;
    localparam logic [2:0] SLT_BU = 3'b100;
    localparam logic [2:0] SLT_HU = 3'b101;

    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_LOAD = 2'b01;
    localparam logic [1:0] WB_PC4  = 2'b10;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mem_state_e;

    // Size field low bits: 00 byte, 01 half, 10 word (bit 2 only selects zero-extension).
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis;
        case (size)
            2'b01:   mis = addr_lo[0];
            2'b10:   mis = (addr_lo != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Store lane replication / byte-enable generation and load lane extraction
// with sign or zero extension.
module lsu_align
    import mem_pkg::*;
(
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_slt,
    input  logic [31:0] i_rs2,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_wdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_ld_data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    assign byte_s = i_rdata[{i_addr_lo, 3'b000} +: 8];
    assign half_s = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

    // Store data replicated to every lane so the byte enables alone pick the target bytes.
    always_comb begin
        o_wdata = i_rs2;
        o_be    = 4'b1111;
        case (i_slt[1:0])
            2'b00: begin
                o_wdata = {4{i_rs2[7:0]}};
                o_be    = 4'b0001 << i_addr_lo;
            end
            2'b01: begin
                o_wdata = {2{i_rs2[15:0]}};
                o_be    = 4'b0011 << {i_addr_lo[1], 1'b0};
            end
            default: begin
                o_wdata = i_rs2;
                o_be    = 4'b1111;
            end
        endcase
    end

    always_comb begin
        o_ld_data = 32'h0000_0000;
        case (i_slt)
            SLT_B:   o_ld_data = {{24{byte_s[7]}}, byte_s};
            SLT_BU:  o_ld_data = {24'h00_0000, byte_s};
            SLT_H:   o_ld_data = {{16{half_s[15]}}, half_s};
            SLT_HU:  o_ld_data = {16'h0000, half_s};
            SLT_W:   o_ld_data = i_rdata;
            default: o_ld_data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/memory_cycle.sv
// MEM stage of the RV32I pipeline: branch/jump resolution, request/ack data
// memory access with pipeline stall, and the MEM/WB pipeline register.
module memory_cycle
    import mem_pkg::*;
(
    input  logic        i_mem_clk,
    input  logic        i_mem_reset_n,
    input  logic [31:0] i_mem_pc,
    input  logic [31:0] i_mem_inst,
    input  logic [31:0] i_mem_alu_data,
    input  logic [31:0] i_mem_rs2_data,
    input  logic        i_mem_lsu_wren,
    input  logic [2:0]  i_mem_slt_sl,
    input  logic [1:0]  i_mem_wb_sel,
    input  logic        i_mem_rd_wren,
    input  logic        i_mem_br_equal,
    input  logic        i_mem_br_less,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic [31:0] o_dmem_addr,
    output logic [31:0] o_dmem_wdata,
    output logic [3:0]  o_dmem_be,
    input  logic [31:0] i_dmem_rdata,
    input  logic        i_dmem_ack,
    output logic        o_mem_stall,
    output logic        o_mem_flush,
    output logic        o_mem_pc_sel,
    output logic [31:0] o_mem_pc_target,
    output logic [31:0] o_mem_fwd_alu_data,
    output logic        o_mem_misalign,
    output logic [31:0] o_mem_pc_wb,
    output logic [31:0] o_mem_inst_wb,
    output logic [31:0] o_mem_alu_data_wb,
    output logic [31:0] o_mem_ld_data_wb,
    output logic [1:0]  o_mem_wb_sel_wb,
    output logic        o_mem_rd_wren_wb
);

    mem_state_e  state_q, state_d;
    logic [31:0] addr_q, addr_d, rs2_q, rs2_d;
    logic [2:0]  slt_q, slt_d;
    logic        we_q, we_d;
    logic        misalign_q, misalign_d;
    logic [31:0] pc_wb_q, pc_wb_d, inst_wb_q, inst_wb_d, alu_wb_q, alu_wb_d, ld_wb_q, ld_wb_d;
    logic [1:0]  wb_sel_wb_q, wb_sel_wb_d;
    logic        rd_wren_wb_q, rd_wren_wb_d;

    logic        mem_op_s, misalign_s, req_s, dmem_req_s, stall_s, done_s, taken_s;
    logic [31:0] acc_addr_s, acc_rs2_s, wdata_s, ld_data_s;
    logic [2:0]  acc_slt_s;
    logic        acc_we_s;
    logic [3:0]  be_s;
    logic [6:0]  opcode_s;
    logic [2:0]  funct3_s;

    assign mem_op_s   = i_mem_lsu_wren | (i_mem_wb_sel == WB_LOAD);
    assign misalign_s = mem_op_s & is_misaligned(i_mem_slt_sl[1:0], i_mem_alu_data[1:0]);
    assign opcode_s   = i_mem_inst[6:0];
    assign funct3_s   = i_mem_inst[14:12];

    // Handshake state register.
    always_ff @(posedge i_mem_clk or negedge i_mem_reset_n) begin
        if (!i_mem_reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a same-cycle ack completes the access without leaving IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = (req_s && !i_dmem_ack) ? BUSY : IDLE;
            BUSY:    state_d = i_dmem_ack ? IDLE : BUSY;
            default: state_d = IDLE;
        endcase
    end

    // Request and access fields; BUSY replays the fields captured at issue.
    always_comb begin
        req_s      = 1'b0;
        acc_addr_s = i_mem_alu_data;
        acc_rs2_s  = i_mem_rs2_data;
        acc_slt_s  = i_mem_slt_sl;
        acc_we_s   = i_mem_lsu_wren;
        case (state_q)
            IDLE: req_s = mem_op_s & ~misalign_s;
            BUSY: begin
                req_s      = 1'b1;
                acc_addr_s = addr_q;
                acc_rs2_s  = rs2_q;
                acc_slt_s  = slt_q;
                acc_we_s   = we_q;
            end
            default: req_s = 1'b0;
        endcase
    end

    lsu_align u_lsu_align (
        .i_addr_lo (acc_addr_s[1:0]),
        .i_slt     (acc_slt_s),
        .i_rs2     (acc_rs2_s),
        .i_rdata   (i_dmem_rdata),
        .o_wdata   (wdata_s),
        .o_be      (be_s),
        .o_ld_data (ld_data_s)
    );

    assign dmem_req_s = req_s & i_mem_reset_n;
    assign stall_s    = dmem_req_s & ~i_dmem_ack;
    assign done_s     = dmem_req_s & i_dmem_ack;

    // Branch / jump decision; br_less already carries signedness from EX.
    always_comb begin
        taken_s = 1'b0;
        case (opcode_s)
            OP_BRANCH: begin
                case (funct3_s)
                    3'b000:         taken_s = i_mem_br_equal;
                    3'b001:         taken_s = ~i_mem_br_equal;
                    3'b100, 3'b110: taken_s = i_mem_br_less;
                    3'b101, 3'b111: taken_s = ~i_mem_br_less;
                    default:        taken_s = 1'b0;
                endcase
            end
            OP_JAL, OP_JALR: taken_s = 1'b1;
            default:         taken_s = 1'b0;
        endcase
    end

    assign o_dmem_req         = dmem_req_s;
    assign o_dmem_we          = acc_we_s & i_mem_reset_n;
    assign o_dmem_addr        = {acc_addr_s[31:2], 2'b00} & {32{i_mem_reset_n}};
    assign o_dmem_wdata       = wdata_s & {32{i_mem_reset_n}};
    assign o_dmem_be          = be_s & {4{i_mem_reset_n}};
    assign o_mem_stall        = stall_s;
    assign o_mem_flush        = taken_s & ~stall_s & i_mem_reset_n;
    assign o_mem_pc_sel       = o_mem_flush;
    assign o_mem_pc_target    = {i_mem_alu_data[31:1], i_mem_alu_data[0] & (opcode_s != OP_JALR)}
                                & {32{i_mem_reset_n}};
    assign o_mem_fwd_alu_data = i_mem_alu_data & {32{i_mem_reset_n}};

    // Access capture, misalign flag and MEM/WB next values (bubble while stalled).
    always_comb begin
        addr_d     = addr_q;
        rs2_d      = rs2_q;
        slt_d      = slt_q;
        we_d       = we_q;
        misalign_d = (state_q == IDLE) & misalign_s;
        if (state_q == IDLE) begin
            addr_d = i_mem_alu_data;
            rs2_d  = i_mem_rs2_data;
            slt_d  = i_mem_slt_sl;
            we_d   = i_mem_lsu_wren;
        end else begin
            addr_d = addr_q;
            rs2_d  = rs2_q;
            slt_d  = slt_q;
            we_d   = we_q;
        end
        if (stall_s) begin
            pc_wb_d      = 32'h0000_0000;
            inst_wb_d    = 32'h0000_0000;
            alu_wb_d     = 32'h0000_0000;
            ld_wb_d      = 32'h0000_0000;
            wb_sel_wb_d  = 2'b00;
            rd_wren_wb_d = 1'b0;
        end else begin
            pc_wb_d      = i_mem_pc;
            inst_wb_d    = i_mem_inst;
            alu_wb_d     = i_mem_alu_data;
            ld_wb_d      = (done_s && !acc_we_s) ? ld_data_s : 32'h0000_0000;
            wb_sel_wb_d  = i_mem_wb_sel;
            rd_wren_wb_d = i_mem_rd_wren & ~misalign_s;
        end
    end

    // Access capture, misalign flag and MEM/WB pipeline register.
    always_ff @(posedge i_mem_clk or negedge i_mem_reset_n) begin
        if (!i_mem_reset_n) begin
            addr_q       <= 32'h0000_0000;
            rs2_q        <= 32'h0000_0000;
            slt_q        <= 3'b000;
            we_q         <= 1'b0;
            misalign_q   <= 1'b0;
            pc_wb_q      <= 32'h0000_0000;
            inst_wb_q    <= 32'h0000_0000;
            alu_wb_q     <= 32'h0000_0000;
            ld_wb_q      <= 32'h0000_0000;
            wb_sel_wb_q  <= 2'b00;
            rd_wren_wb_q <= 1'b0;
        end else begin
            addr_q       <= addr_d;
            rs2_q        <= rs2_d;
            slt_q        <= slt_d;
            we_q         <= we_d;
            misalign_q   <= misalign_d;
            pc_wb_q      <= pc_wb_d;
            inst_wb_q    <= inst_wb_d;
            alu_wb_q     <= alu_wb_d;
            ld_wb_q      <= ld_wb_d;
            wb_sel_wb_q  <= wb_sel_wb_d;
            rd_wren_wb_q <= rd_wren_wb_d;
        end
    end

    assign o_mem_misalign    = misalign_q;
    assign o_mem_pc_wb       = pc_wb_q;
    assign o_mem_inst_wb     = inst_wb_q;
    assign o_mem_alu_data_wb = alu_wb_q;
    assign o_mem_ld_data_wb  = ld_wb_q;
    assign o_mem_wb_sel_wb   = wb_sel_wb_q;
    assign o_mem_rd_wren_wb  = rd_wren_wb_q;

endmodule

// File: tb/tb_memory_cycle.sv
// Directed-vector bench for memory_cycle: stimulus pushes expected memory
// transactions and MEM/WB records; a negedge monitor pops and compares them.
module tb_memory_cycle;

    logic        clk, rst_n;
    logic [31:0] pc, inst, alu, rs2, rdata;
    logic        wren, rdw, eq, lt, ack;
    logic [2:0]  slt;
    logic [1:0]  wbsel;
    logic        dmem_req, dmem_we, stall, flush, pc_sel, misalign, rd_wren_wb;
    logic [31:0] dmem_addr, dmem_wdata, pc_target, fwd, pc_wb, inst_wb, alu_wb, ld_wb;
    logic [3:0]  dmem_be;
    logic [1:0]  wb_sel_wb;

    typedef struct { logic [31:0] addr; logic we; logic [31:0] wdata; logic [3:0] be; } dm_t;
    typedef struct { logic [31:0] pc, inst, alu, ld; logic [1:0] sel; logic rdw; } wb_t;
    dm_t dm_q[$];
    wb_t wb_q[$];

    int n_chk  = 0;
    int n_fail = 0;

    memory_cycle dut (
        .i_mem_clk(clk), .i_mem_reset_n(rst_n),
        .i_mem_pc(pc), .i_mem_inst(inst), .i_mem_alu_data(alu), .i_mem_rs2_data(rs2),
        .i_mem_lsu_wren(wren), .i_mem_slt_sl(slt), .i_mem_wb_sel(wbsel), .i_mem_rd_wren(rdw),
        .i_mem_br_equal(eq), .i_mem_br_less(lt),
        .o_dmem_req(dmem_req), .o_dmem_we(dmem_we), .o_dmem_addr(dmem_addr),
        .o_dmem_wdata(dmem_wdata), .o_dmem_be(dmem_be),
        .i_dmem_rdata(rdata), .i_dmem_ack(ack),
        .o_mem_stall(stall), .o_mem_flush(flush), .o_mem_pc_sel(pc_sel),
        .o_mem_pc_target(pc_target), .o_mem_fwd_alu_data(fwd), .o_mem_misalign(misalign),
        .o_mem_pc_wb(pc_wb), .o_mem_inst_wb(inst_wb), .o_mem_alu_data_wb(alu_wb),
        .o_mem_ld_data_wb(ld_wb), .o_mem_wb_sel_wb(wb_sel_wb), .o_mem_rd_wren_wb(rd_wren_wb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: pop expectations whenever the DUT completes an access or presents a WB entry.
    always @(negedge clk) begin
        if (rst_n) begin
            if (dmem_req && ack) begin
                if (dm_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL dmem_unexpected: got access at %h expected none", dmem_addr);
                end else begin
                    dm_t e;
                    e = dm_q.pop_front();
                    chk("dmem_addr", dmem_addr, e.addr);
                    chk("dmem_we", {31'd0, dmem_we}, {31'd0, e.we});
                    if (e.we) begin
                        chk("dmem_wdata", dmem_wdata, e.wdata);
                        chk("dmem_be", {28'd0, dmem_be}, {28'd0, e.be});
                    end
                end
            end
            if (inst_wb != 32'd0) begin
                if (wb_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL wb_unexpected: got inst %h expected none", inst_wb);
                end else begin
                    wb_t w;
                    w = wb_q.pop_front();
                    chk("wb_pc", pc_wb, w.pc);
                    chk("wb_inst", inst_wb, w.inst);
                    chk("wb_alu", alu_wb, w.alu);
                    chk("wb_ld", ld_wb, w.ld);
                    chk("wb_sel", {30'd0, wb_sel_wb}, {30'd0, w.sel});
                    chk("wb_rdw", {31'd0, rd_wren_wb}, {31'd0, w.rdw});
                end
            end
        end
    end

    task automatic idle_inputs();
        pc = 32'd0; inst = 32'd0; alu = 32'd0; rs2 = 32'd0; rdata = 32'd0;
        wren = 1'b0; rdw = 1'b0; eq = 1'b0; lt = 1'b0; ack = 1'b0;
        slt = 3'b000; wbsel = 2'b00;
    endtask

    task automatic issue(input logic [31:0] i_pc, i_inst, i_alu, i_rs2, input logic i_wren,
                         input logic [2:0] i_slt, input logic [1:0] i_wbsel, input logic i_rdw,
                         input logic i_eq, i_lt, input logic [31:0] i_rdata, input int dly,
                         input logic [31:0] exp_ld, exp_wd, input logic [3:0] exp_be,
                         input logic exp_mis, exp_flush, input logic [31:0] exp_tgt);
        logic exp_req;
        exp_req = (i_wren | (i_wbsel == 2'b01)) & ~exp_mis;
        if (exp_req) dm_q.push_back('{i_alu & 32'hFFFF_FFFC, i_wren, exp_wd, exp_be});
        wb_q.push_back('{i_pc, i_inst, i_alu, exp_ld, i_wbsel, i_rdw & ~exp_mis});
        @(posedge clk); #1;
        pc = i_pc; inst = i_inst; alu = i_alu; rs2 = i_rs2; wren = i_wren; slt = i_slt;
        wbsel = i_wbsel; rdw = i_rdw; eq = i_eq; lt = i_lt; rdata = i_rdata;
        ack = (dly == 0);
        for (int k = 0; k < dly; k++) begin
            @(negedge clk);
            chk("stall_wait", {31'd0, stall}, 32'd1);
            chk("req_hold", {31'd0, dmem_req}, 32'd1);
            chk("addr_hold", dmem_addr, i_alu & 32'hFFFF_FFFC);
            chk("we_hold", {31'd0, dmem_we}, {31'd0, i_wren});
            chk("wb_bubble", inst_wb, 32'd0);
            @(posedge clk); #1;
            if (k == dly - 1) ack = 1'b1;
        end
        @(negedge clk);
        chk("stall_done", {31'd0, stall}, 32'd0);
        chk("req", {31'd0, dmem_req}, {31'd0, exp_req});
        chk("wb_prev_bubble", inst_wb, 32'd0);
        chk("flush", {31'd0, flush}, {31'd0, exp_flush});
        chk("pc_sel", {31'd0, pc_sel}, {31'd0, exp_flush});
        if (exp_flush) chk("pc_target", pc_target, exp_tgt);
        chk("fwd", fwd, i_alu);
        @(posedge clk); #1;
        idle_inputs();
        chk("misalign", {31'd0, misalign}, {31'd0, exp_mis});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        alu = 32'h0000_0123; inst = 32'h008000EF; wbsel = 2'b01;
        #12;
        chk("rst_req", {31'd0, dmem_req}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_flush", {31'd0, flush}, 32'd0);
        chk("rst_target", pc_target, 32'd0);
        chk("rst_fwd", fwd, 32'd0);
        chk("rst_addr", dmem_addr, 32'd0);
        chk("rst_misalign", {31'd0, misalign}, 32'd0);
        chk("rst_inst_wb", inst_wb, 32'd0);
        chk("rst_pc_wb", pc_wb, 32'd0);
        chk("rst_rdw_wb", {31'd0, rd_wren_wb}, 32'd0);
        idle_inputs();
        @(negedge clk); rst_n = 1'b1;

        //    pc           inst          alu           rs2          we  slt     wb     rdw eq lt rdata        dly exp_ld        exp_wd        be       mis fl tgt
        issue(32'h0000_0010, 32'h0011_2223, 32'h0000_0104, 32'hDEAD_BEEF, 1, 3'b010, 2'b00, 0, 0, 0, 32'h0,        0, 32'h0,        32'hDEAD_BEEF, 4'b1111, 0, 0, 32'h0);
        issue(32'h0000_0014, 32'h0030_0083, 32'h0000_0103, 32'h0,         0, 3'b000, 2'b01, 1, 0, 0, 32'h8011_2233, 0, 32'hFFFF_FF80, 32'h0,        4'b0000, 0, 0, 32'h0);
        issue(32'h0000_0018, 32'h0030_4083, 32'h0000_0103, 32'h0,         0, 3'b100, 2'b01, 1, 0, 0, 32'h8011_2233, 0, 32'h0000_0080, 32'h0,        4'b0000, 0, 0, 32'h0);
        issue(32'h0000_001C, 32'h0020_9123, 32'h0000_0102, 32'h0000_ABCD, 1, 3'b001, 2'b00, 0, 0, 0, 32'h0,        0, 32'h0,        32'hABCD_ABCD, 4'b1100, 0, 0, 32'h0);
        issue(32'h0000_0020, 32'h0010_80A3, 32'h0000_0101, 32'h1234_56A5, 1, 3'b000, 2'b00, 0, 0, 0, 32'h0,        0, 32'h0,        32'hA5A5_A5A5, 4'b0010, 0, 0, 32'h0);
        issue(32'h0000_0024, 32'h0080_2083, 32'h0000_0108, 32'h0,         0, 3'b010, 2'b01, 1, 0, 0, 32'h1234_5678, 3, 32'h1234_5678, 32'h0,        4'b0000, 0, 0, 32'h0);
        issue(32'h0000_0028, 32'h0020_1083, 32'h0000_0102, 32'h0,         0, 3'b001, 2'b01, 1, 0, 0, 32'h8001_1234, 1, 32'hFFFF_8001, 32'h0,        4'b0000, 0, 0, 32'h0);
        issue(32'h0000_002C, 32'h0000_5083, 32'h0000_0100, 32'h0,         0, 3'b101, 2'b01, 1, 0, 0, 32'h8001_F234, 0, 32'h0000_F234, 32'h0,        4'b0000, 0, 0, 32'h0);
        issue(32'h0000_0030, 32'h0020_9463, 32'h0000_0200, 32'h0,         0, 3'b000, 2'b00, 0, 0, 0, 32'h0,        0, 32'h0,        32'h0,        4'b0000, 0, 1, 32'h0000_0200);
        issue(32'h0000_0034, 32'h0020_8463, 32'h0000_0208, 32'h0,         0, 3'b000, 2'b00, 0, 0, 0, 32'h0,        0, 32'h0,        32'h0,        4'b0000, 0, 0, 32'h0);
        issue(32'h0000_0038, 32'h0020_C463, 32'h0000_0240, 32'h0,         0, 3'b000, 2'b00, 0, 0, 1, 32'h0,        0, 32'h0,        32'h0,        4'b0000, 0, 1, 32'h0000_0240);
        issue(32'h0000_003C, 32'h0020_F463, 32'h0000_0248, 32'h0,         0, 3'b000, 2'b00, 0, 0, 1, 32'h0,        0, 32'h0,        32'h0,        4'b0000, 0, 0, 32'h0);
        issue(32'h0000_0040, 32'h0080_00EF, 32'h0000_0400, 32'h0,         0, 3'b000, 2'b10, 1, 0, 0, 32'h0,        0, 32'h0,        32'h0,        4'b0000, 0, 1, 32'h0000_0400);
        issue(32'h0000_0044, 32'h0000_80E7, 32'h0000_0301, 32'h0,         0, 3'b000, 2'b10, 1, 0, 0, 32'h0,        0, 32'h0,        32'h0,        4'b0000, 0, 1, 32'h0000_0300);
        issue(32'h0000_0048, 32'h0020_81B3, 32'h0000_0055, 32'h0,         0, 3'b000, 2'b00, 1, 0, 0, 32'h0,        0, 32'h0,        32'h0,        4'b0000, 0, 0, 32'h0);
        issue(32'h0000_004C, 32'h0010_1083, 32'h0000_0101, 32'h0,         0, 3'b001, 2'b01, 1, 0, 0, 32'hFFFF_FFFF, 0, 32'h0,        32'h0,        4'b0000, 1, 0, 32'h0);
        issue(32'h0000_0050, 32'h0011_2323, 32'h0000_0106, 32'h1111_2222, 1, 3'b010, 2'b00, 0, 0, 0, 32'h0,        0, 32'h0,        32'h0,        4'b0000, 1, 0, 32'h0);

        // Reset asserted while an access is outstanding in BUSY.
        @(posedge clk); #1;
        pc = 32'h0000_0054; inst = 32'h00C0_2083; alu = 32'h0000_010C; slt = 3'b010;
        wbsel = 2'b01; rdw = 1'b1; ack = 1'b0;
        @(negedge clk);
        chk("busy_req_issue", {31'd0, dmem_req}, 32'd1);
        @(posedge clk); #1;
        chk("busy_req_held", {31'd0, dmem_req}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_busy_req", {31'd0, dmem_req}, 32'd0);
        chk("rst_busy_stall", {31'd0, stall}, 32'd0);
        chk("rst_busy_inst_wb", inst_wb, 32'd0);
        idle_inputs();
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_idle_req", {31'd0, dmem_req}, 32'd0);
        issue(32'h0000_0058, 32'h0011_2423, 32'h0000_0108, 32'hCAFE_F00D, 1, 3'b010, 2'b00, 0, 0, 0, 32'h0, 0, 32'h0, 32'hCAFE_F00D, 4'b1111, 0, 0, 32'h0);

        repeat (3) @(posedge clk);
        #1;
        chk("dm_queue_empty", dm_q.size(), 32'd0);
        chk("wb_queue_empty", wb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
